// File: rtl/systolic_wb_ctrl_pkg.sv
// Shared definitions for the Frodo systolic fetch/write-back controllers:
// memory mode codes, Frodo matrix constants and mode helpers.
package systolic_wb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AS   = 3'd1,
        SA   = 3'd2,
        SB   = 3'd3,
        BS   = 3'd4
    } mem_mode_t;

    localparam int FRODO_N    = 1344;
    localparam int FRODO_NBAR = 8;
    localparam int ELEM_W     = 16;
    localparam int LANES      = 4;

    function automatic logic is_row_major(mem_mode_t m);
        return (m == AS) || (m == SB);
    endfunction

    function automatic logic is_valid_mode(logic [2:0] m);
        return (m >= 3'd1) && (m <= 3'd4);
    endfunction

endpackage

// File: rtl/systolic_wb_ctrl_addr_gen.sv
// Word counters and byte address mux for the write-back controller.
// Ports: clk, rst_n, clear/inc (counter control), row_major (order select),
// addr (byte address of current word), last (current word is the final one).
module wb_addr_gen
    import systolic_wb_ctrl_pkg::*;
#(
    parameter int          N_ROWS    = FRODO_N,
    parameter int          N_COLS    = FRODO_NBAR,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        inc,
    input  logic        row_major,
    output logic [31:0] addr,
    output logic        last
);

    localparam int WPR   = N_COLS / LANES;
    localparam int ROW_W = $clog2(N_ROWS + 1);
    localparam int COL_W = $clog2(WPR + 1);

    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] col_cnt;
    logic             col_end;
    logic [31:0]      idx;

    assign col_end = (col_cnt == COL_W'(WPR - 1));
    assign last    = col_end && (row_cnt == ROW_W'(N_ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (clear) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (inc && !last) begin
            if (col_end) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        if (row_major)
            idx = 32'(row_cnt) * 32'(WPR) + 32'(col_cnt);
        else
            idx = 32'(col_cnt) * 32'(N_ROWS) + 32'(row_cnt);
        addr = BASE_ADDR + (idx << 3);
    end

endmodule

// File: rtl/systolic_wb_ctrl.sv
// Result write-back controller: writes 4x16-bit result words to BRAM in
// row-major or transposed order, optionally accumulating existing contents.
// Ports: clk, rst_n; wb_init/wb_mode/acc_en start a transfer; res_valid,
// res_data, res_ready form the result stream handshake; bram_re, bram_we,
// bram_addr, bram_wdata, bram_rdata drive the result BRAM; wb_busy and
// wb_done report progress.
module systolic_wb_ctrl
    import systolic_wb_ctrl_pkg::*;
#(
    parameter int          N_ROWS    = FRODO_N,
    parameter int          N_COLS    = FRODO_NBAR,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_init,
    input  logic [2:0]  wb_mode,
    input  logic        acc_en,
    input  logic        res_valid,
    input  logic [63:0] res_data,
    output logic        res_ready,
    output logic        bram_re,
    output logic        bram_we,
    output logic [31:0] bram_addr,
    output logic [63:0] bram_wdata,
    input  logic [63:0] bram_rdata,
    output logic        wb_busy,
    output logic        wb_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_RD     = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WR     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        acc_q;
    logic        row_major_q;
    logic        last_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] sum;
    logic [31:0] gen_addr;
    logic        gen_last;
    logic        init_ok;
    logic        hs;

    assign init_ok   = wb_init && is_valid_mode(wb_mode);
    assign res_ready = (state == S_ACCEPT);
    // A restart in the same cycle wins over a word offered in ACCEPT.
    assign hs        = res_valid && res_ready && !wb_init;

    assign bram_re    = (state == S_RD);
    assign bram_we    = (state == S_WR);
    assign wb_done    = (state == S_DONE);
    assign wb_busy    = (state != S_IDLE) && (state != S_DONE);
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;

    wb_addr_gen #(
        .N_ROWS    (N_ROWS),
        .N_COLS    (N_COLS),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (init_ok),
        .inc       (hs),
        .row_major (row_major_q),
        .addr      (gen_addr),
        .last      (gen_last)
    );

    // Lane-wise add, no carry between 16-bit lanes.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum[i*ELEM_W +: ELEM_W] = wdata_q[i*ELEM_W +: ELEM_W]
                                    + bram_rdata[i*ELEM_W +: ELEM_W];
    end

    always_comb begin
        state_nxt = state;
        if (wb_init && (state != S_IDLE)) begin
            state_nxt = init_ok ? S_ACCEPT : S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (init_ok) state_nxt = S_ACCEPT;
                S_ACCEPT: if (hs) state_nxt = acc_q ? S_RD : S_WR;
                S_RD:     state_nxt = S_WAIT;
                S_WAIT:   state_nxt = S_WR;
                S_WR:     state_nxt = last_q ? S_DONE : S_ACCEPT;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc_q       <= 1'b0;
            row_major_q <= 1'b0;
            last_q      <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
        end else begin
            state <= state_nxt;
            if (init_ok) begin
                acc_q       <= acc_en;
                row_major_q <= is_row_major(mem_mode_t'(wb_mode));
            end
            if (hs) begin
                addr_q  <= gen_addr;
                wdata_q <= res_data;
                last_q  <= gen_last;
            end else if (state == S_WAIT) begin
                wdata_q <= sum;
            end
        end
    end

endmodule

// File: tb/tb_systolic_wb_ctrl.sv
// Self-checking bench for systolic_wb_ctrl: transaction-level model plus
// directed transfers with hand-computed expectations.
module tb_systolic_wb_ctrl;

    localparam int N_ROWS = 1344;
    localparam int WPR    = 2;
    localparam int TOTAL  = N_ROWS * WPR;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_init = 1'b0;
    logic [2:0]  wb_mode = 3'd0;
    logic        acc_en = 1'b0;
    logic        res_valid = 1'b0;
    logic [63:0] res_data = '0;
    logic        res_ready;
    logic        bram_re;
    logic        bram_we;
    logic [31:0] bram_addr;
    logic [63:0] bram_wdata;
    logic [63:0] bram_rdata;
    logic        wb_busy;
    logic        wb_done;

    systolic_wb_ctrl #(
        .N_ROWS    (N_ROWS),
        .N_COLS    (8),
        .BASE_ADDR (32'd0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_init    (wb_init),
        .wb_mode    (wb_mode),
        .acc_en     (acc_en),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .bram_re    (bram_re),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model state
    int          cyc = 0;
    bit          m_active = 0;
    bit          m_acc = 0;
    int          m_mode = 0;
    int          m_k = 0;
    int          m_ready_at = 0;
    int          m_re_at = -1;
    int          m_we_at = -1;
    int          m_done_at = -1;
    logic [31:0] m_addr = '0;
    logic [63:0] m_data = '0;
    logic [63:0] rd_const = '0;
    int          data_sel = 0;

    // Observations
    logic [31:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    int          we_cyc_q[$];
    int          re_cyc_q[$];
    int          hs_cyc_q[$];
    logic [31:0] ref_addr_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    assign bram_rdata = rd_const;

    function automatic logic [31:0] model_addr(int mode, int k);
        if (mode == 1 || mode == 3)
            return 32'(k * 8);
        return 32'(((k % WPR) * N_ROWS + k / WPR) * 8);
    endfunction

    function automatic logic [63:0] lane_sum(logic [63:0] a, logic [63:0] b);
        logic [63:0] r;
        for (int i = 0; i < 4; i++)
            r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        return r;
    endfunction

    function automatic logic [31:0] wa(int i);
        if (i < 0 || i >= wr_addr_q.size()) return 32'hDEAD_BEEF;
        return wr_addr_q[i];
    endfunction

    function automatic logic [63:0] wd(int i);
        if (i < 0 || i >= wr_data_q.size()) return 64'hDEAD_BEEF;
        return wr_data_q[i];
    endfunction

    function automatic int qi(int q[$], int i);
        if (i < 0 || i >= q.size()) return -1000;
        return q[i];
    endfunction

    always @(negedge clk) begin
        bit e_ready;
        bit hs;
        if (!rst_n) begin
            m_active  = 0;
            m_re_at   = -1;
            m_we_at   = -1;
            m_done_at = -1;
            chk("rst_ready", res_ready, 0);
            chk("rst_we", bram_we, 0);
            chk("rst_busy", wb_busy, 0);
        end else begin
            e_ready = m_active && cyc >= m_ready_at && m_k < TOTAL;
            chk("ready", res_ready, e_ready);
            chk("re", bram_re, cyc == m_re_at);
            chk("we", bram_we, cyc == m_we_at);
            chk("done", wb_done, cyc == m_done_at);
            chk("busy", wb_busy, m_active && cyc != m_done_at);
            if (cyc == m_re_at) chk("re_addr", bram_addr, m_addr);
            if (cyc == m_we_at) begin
                chk("we_addr", bram_addr, m_addr);
                chk("wdata", bram_wdata, m_data);
            end
            if (bram_we) begin
                wr_addr_q.push_back(bram_addr);
                wr_data_q.push_back(bram_wdata);
                we_cyc_q.push_back(cyc);
            end
            if (bram_re) re_cyc_q.push_back(cyc);
            if (wb_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == m_done_at) m_active = 0;
            hs = res_valid && e_ready;
            if (wb_init) begin
                if (wb_mode inside {[1:4]}) begin
                    m_active   = 1;
                    m_mode     = int'(wb_mode);
                    m_acc      = acc_en;
                    m_k        = 0;
                    m_ready_at = cyc + 1;
                end else begin
                    m_active = 0;
                end
                m_re_at   = -1;
                m_done_at = -1;
                if (m_we_at > cyc) m_we_at = -1;
            end else if (hs) begin
                m_addr = model_addr(m_mode, m_k);
                m_data = m_acc ? lane_sum(res_data, rd_const) : res_data;
                if (m_acc) begin
                    m_re_at    = cyc + 1;
                    m_we_at    = cyc + 3;
                    m_ready_at = cyc + 4;
                end else begin
                    m_we_at    = cyc + 1;
                    m_ready_at = cyc + 2;
                end
                hs_cyc_q.push_back(cyc);
                m_k++;
                if (m_k == TOTAL) m_done_at = m_we_at + 1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        wr_addr_q.delete();
        wr_data_q.delete();
        we_cyc_q.delete();
        re_cyc_q.delete();
        hs_cyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic drive_word(input int pct);
        res_valid = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
        res_data  = (data_sel == 0) ? 64'(m_k) : 64'h0002_0002_0002_0002;
    endtask

    task automatic start(input logic [2:0] mode, input logic acc);
        wb_init = 1'b1;
        wb_mode = mode;
        acc_en  = acc;
        tick();
        wb_init = 1'b0;
    endtask

    task automatic run(input string name, input int pct, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            drive_word(pct);
            tick();
            n++;
        end
        res_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: got no wb_done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int mism;
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_ready", res_ready, 0);
        chk("reset_re", bram_re, 0);
        chk("reset_we", bram_we, 0);
        chk("reset_busy", wb_busy, 0);
        chk("reset_done", wb_done, 0);
        chk("reset_addr", bram_addr, 0);
        chk("reset_wdata", bram_wdata, 0);
        rst_n = 1'b1;
        tick();

        // AS, no accumulate, gap-free, data = word index
        clear_rec();
        data_sel = 0;
        start(3'd1, 1'b0);
        chk("as_ready_after_init", res_ready, 1);
        run("as", 100, 7000);
        chk("as_count", wr_addr_q.size(), TOTAL);
        chk("as_addr0", wa(0), 0);
        chk("as_addr_last", wa(TOTAL - 1), 21496);
        chk("as_data5", wd(5), 5);
        chk("as_done_cnt", done_cnt, 1);
        chk("as_done_lat", done_cyc - qi(hs_cyc_q, hs_cyc_q.size() - 1), 2);
        chk("as_we_spacing", qi(we_cyc_q, 1) - qi(we_cyc_q, 0), 2);
        ref_addr_q = wr_addr_q;

        // SA, transposed order
        clear_rec();
        start(3'd2, 1'b0);
        run("sa", 100, 7000);
        chk("sa_count", wr_addr_q.size(), TOTAL);
        chk("sa_addr1", wa(1), 10752);
        chk("sa_addr2", wa(2), 8);
        chk("sa_addr_last", wa(TOTAL - 1), 21496);

        // BS, accumulate, FFFF + 0002 per lane
        clear_rec();
        data_sel = 1;
        rd_const = 64'hFFFF_FFFF_FFFF_FFFF;
        start(3'd4, 1'b1);
        run("bs", 100, 13000);
        chk("bs_count", wr_addr_q.size(), TOTAL);
        chk("bs_wdata0", wd(0), 64'h0001_0001_0001_0001);
        chk("bs_addr1", wa(1), 10752);
        chk("bs_re_to_we", qi(we_cyc_q, 0) - qi(re_cyc_q, 0), 2);
        chk("bs_hs_spacing", qi(hs_cyc_q, 1) - qi(hs_cyc_q, 0), 4);
        chk("bs_done_cnt", done_cnt, 1);

        // AS with random valid gaps
        clear_rec();
        data_sel = 0;
        rd_const = '0;
        start(3'd1, 1'b0);
        run("gap", 60, 30000);
        chk("gap_count", wr_addr_q.size(), ref_addr_q.size());
        mism = 0;
        for (int i = 0; i < ref_addr_q.size(); i++)
            if (wa(i) !== ref_addr_q[i]) mism++;
        chk("gap_order", mism, 0);
        chk("gap_we_eq_hs", we_cyc_q.size(), hs_cyc_q.size());

        // Restart mid-transfer at word 100 with SA
        clear_rec();
        start(3'd1, 1'b0);
        n = 0;
        while (m_k < 100 && n < 1000) begin
            drive_word(100);
            tick();
            n++;
        end
        res_valid = 1'b0;
        wb_init   = 1'b1;
        wb_mode   = 3'd2;
        acc_en    = 1'b0;
        tick();
        wb_init = 1'b0;
        chk("abort_writes_before", wr_addr_q.size(), 100);
        chk("abort_no_done", done_cnt, 0);
        run("abort", 100, 7000);
        chk("abort_count", wr_addr_q.size(), 100 + TOTAL);
        chk("abort_new_w0", wa(100), 0);
        chk("abort_new_w1", wa(101), 10752);
        chk("abort_done_cnt", done_cnt, 1);
        chk("abort_done_after_last",
            done_cyc - qi(we_cyc_q, we_cyc_q.size() - 1), 1);

        // Reset while in WAIT
        clear_rec();
        data_sel = 1;
        rd_const = 64'hFFFF_FFFF_FFFF_FFFF;
        start(3'd4, 1'b1);
        n = 0;
        while (re_cyc_q.size() < 3 && n < 100) begin
            drive_word(100);
            tick();
            n++;
        end
        res_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("wrst_ready", res_ready, 0);
        chk("wrst_re", bram_re, 0);
        chk("wrst_we", bram_we, 0);
        chk("wrst_busy", wb_busy, 0);
        chk("wrst_done", wb_done, 0);
        chk("wrst_addr", bram_addr, 0);
        chk("wrst_wdata", bram_wdata, 0);
        n = wr_addr_q.size();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        wb_init = 1'b1;
        wb_mode = 3'd0;
        tick();
        wb_init = 1'b0;
        repeat (4) tick();
        chk("mode0_busy", wb_busy, 0);
        chk("mode0_ready", res_ready, 0);
        chk("mode0_no_write", wr_addr_q.size(), n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_wb_ctrl.md
# systolic_wb_ctrl

Result write-back controller for the Frodo systolic multiplier. It is the write-side counterpart of the operand-fetch controller: it accepts 64-bit result words (four 16-bit lanes) streamed out of the systolic array and writes them into the result BRAM. The row-major/transposed address order is chosen by the same AS/SA/SB/BS mode code the fetch side uses. It can optionally add the existing BRAM contents lane-wise (B = A·S + E) through a read-modify-write sequence.

## Interface
Parameters:
- N_ROWS, 1344: result lines (Frodo n)
- N_COLS, 8: 16-bit elements per line (nbar); must be a multiple of 4
- BASE_ADDR, 32'd0: byte address of the first result word

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wb_init  in  1  one-cycle start pulse; samples wb_mode and acc_en
- wb_mode  in  3  0 IDLE, 1 AS, 2 SA, 3 SB, 4 BS
- acc_en  in  1  1 = read-modify-write (add existing word)
- res_valid  in  1  array result word valid
- res_data  in  64  four 16-bit lanes, lane 0 = bits [15:0]
- res_ready  out  1  controller accepts res_data this cycle
- bram_re  out  1  read strobe (accumulate mode only)
- bram_we  out  1  write strobe
- bram_addr  out  32  byte address, 8-byte aligned
- bram_wdata  out  64  write data
- bram_rdata  in  64  read data; valid the cycle after bram_re
- wb_busy  out  1  high from the cycle after an accepted init until done
- wb_done  out  1  one-cycle pulse after the final write

## Operation
- WPR = N_COLS/4 words per line. TOTAL = N_ROWS*WPR, which is 2688 at the defaults.
- Counters: col_cnt runs 0..WPR-1 (inner), row_cnt runs 0..N_ROWS-1 (outer). They advance once per accepted word.
- Address calculation:
  - AS/SB: addr = BASE_ADDR + (row_cnt*WPR + col_cnt)*8.
  - SA/BS: addr = BASE_ADDR + (col_cnt*N_ROWS + row_cnt)*8.
  - All arithmetic is 32-bit unsigned.
- Accumulate sum: per lane, (res lane + rdata lane) mod 2^16. There is no carry between lanes.
- FSM states:
  - IDLE: ready=0. wb_init with mode 1..4 → ACCEPT, counters cleared. wb_init with mode 0 is ignored.
  - ACCEPT: ready=1. On handshake (valid&&ready): if acc_en → RD, else → WR.
  - RD: ready=0. bram_re=1 at the captured address → WAIT.
  - WAIT: ready=0. Sum is registered from bram_rdata → WR.
  - WR: bram_we=1 with the captured or summed data. Then → DONE if this was word TOTAL-1, else → ACCEPT.
  - DONE: wb_done=1 for one cycle → IDLE.
- The accepted word and its address are latched on handshake. bram_addr holds its value through RD/WAIT/WR.
- wb_init in any non-IDLE state aborts the current transfer with no further writes and restarts with the new mode and counters cleared. A write already in WR in that same cycle still completes.
- res_valid while ready=0 is held off. The data is not sampled.

## Timing
- Reset values: res_ready, bram_re, bram_we, wb_busy and wb_done = 0; bram_addr = BASE_ADDR; bram_wdata = 0; FSM = IDLE; counters = 0.
- wb_init at cycle t → ready=1 and busy=1 at t+1.
- Non-accumulate mode: handshake at t → bram_we at t+1 → ready at t+2. Throughput is 1 word per 2 cycles.
- Accumulate mode: handshake at t → bram_re at t+1 → rdata sampled at t+2 → bram_we at t+3 → ready at t+4.
- wb_done is asserted in the cycle after the last bram_we. busy falls in the same cycle done is asserted.
- Counter wrap: at col_cnt=WPR-1, col_cnt→0 and row_cnt increments. The final word is detected at row_cnt=N_ROWS-1 with col_cnt=WPR-1; there is no wrap past it.

## Structure
- Shared package (also used by the fetch controller):
  - mem_mode_t enum: IDLE=0, AS=1, SA=2, SB=3, BS=4.
  - Frodo constants: n=1344, nbar=8, element width 16.
  - is_row_major(mode) function: true for AS/SB.
- Sub-module wb_addr_gen: the counters plus the address mux, driven by inc/clear.
- Lane adder: inline.

## Test plan
- AS mode, acc_en=0, res_valid constantly high, res_data=word index:
  - 2688 writes; word k at addr 8k.
  - Single wb_done two cycles after the last handshake.
- SA mode, defaults:
  - Word 1 at addr 1344*8 = 10752; word 2 at addr 8.
  - Last word at (1*1344+1343)*8.
- BS mode, acc_en=1, bram_rdata lane = 16'hFFFF, result lane = 16'h0002:
  - Written lanes = 16'h0001.
  - bram_re precedes bram_we by 2 cycles; ready low for 3 cycles per word.
- Random res_valid gaps:
  - Write count and address order are identical to the gap-free run.
  - No write occurs without a handshake.
- wb_init mid-transfer at word 100 with a new mode:
  - No stale writes; the next write lands at the new mode's word 0.
  - wb_done is asserted only after the new full transfer.
- Reset asserted mid-transfer in WAIT:
  - All outputs take their reset values immediately.
  - wb_init with mode 0 leaves the block in IDLE.
